// File: rtl/pe_os_acc.sv
// pe_os_acc: output-stationary MAC processing element.
// Forwards operands systolically (1-cycle register) and accumulates a
// k_len-term dot product, then holds the result under a valid/ready handshake.
// Optional feature: define PE_ACC_SAT_EN to saturate the accumulator on
// overflow instead of wrapping.
module pe_os_acc #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 20,  // must be >= 2*DATA_W so one product always fits
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              start,
  input  logic [CNT_W-1:0]  k_len,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] data_in,
  input  logic [DATA_W-1:0] weight_in,
  output logic [DATA_W-1:0] data_out,
  output logic [DATA_W-1:0] weight_out,
  output logic              valid_out,
  output logic              busy,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [ACC_W-1:0]  res_data,
  output logic              ovf
);
  localparam int PROD_W = 2*DATA_W;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ACCUM = 2'd1;
  localparam logic [1:0] S_HOLD  = 2'd2;

  typedef struct packed {
    logic [DATA_W-1:0] d;
    logic [DATA_W-1:0] w;
  } opnd_t;

  opnd_t              fwd_q;
  logic               fwd_vld;
  logic [1:0]         state;
  logic [ACC_W-1:0]   acc;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   klen_q;
  logic               ovf_q;

  logic [PROD_W-1:0]  prod;
  logic [ACC_W:0]     sum;
  logic               add_ovf;
  logic [ACC_W-1:0]   acc_nx;
  logic [CNT_W-1:0]   cnt_nx;

  // Product and carry-out sum; the extra MSB of sum is the overflow detect.
  always_comb begin
    prod    = PROD_W'(data_in) * PROD_W'(weight_in);
    sum     = {1'b0, acc} + (ACC_W+1)'(prod);
    add_ovf = sum[ACC_W];
    cnt_nx  = cnt + CNT_W'(1);
`ifdef PE_ACC_SAT_EN
    // Once saturated, any further nonzero product overflows again, so acc
    // stays pinned at all-ones for the rest of the dot product.
    acc_nx  = add_ovf ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
`else
    acc_nx  = sum[ACC_W-1:0];
`endif
  end

  // Systolic forward path: registered every cycle regardless of FSM state.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      fwd_q   <= '0;
      fwd_vld <= 1'b0;
    end else begin
      fwd_q   <= '{d: data_in, w: weight_in};
      fwd_vld <= in_valid;
    end
  end

  // Control FSM and accumulator; clear acts as a synchronous abort.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      state  <= S_IDLE;
      acc    <= '0;
      cnt    <= '0;
      klen_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            klen_q <= k_len;
            acc    <= '0;
            cnt    <= '0;
            ovf_q  <= 1'b0;
            state  <= (k_len == '0) ? S_HOLD : S_ACCUM;
          end
        end
        S_ACCUM: begin
          if (in_valid) begin
            acc <= acc_nx;
            cnt <= cnt_nx;
            if (add_ovf) ovf_q <= 1'b1;
            if (cnt_nx == klen_q) state <= S_HOLD;
          end
        end
        S_HOLD: begin
          // start is deliberately ignored here, even alongside res_ready
          if (res_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign data_out   = fwd_q.d;
  assign weight_out = fwd_q.w;
  assign valid_out  = fwd_vld;
  assign busy       = (state == S_ACCUM) || (state == S_HOLD);
  assign res_valid  = (state == S_HOLD);
  assign res_data   = (state == S_HOLD) ? acc : '0;
  assign ovf        = ovf_q;

endmodule
